// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
// store_rmw_unit: SB/SH/SW stores to a word-only memory via read-modify-write
// Revision: 1.0
// ============================================================================
module store_rmw_unit #(
  parameter int ADDR_W    = 32,
  parameter bit SW_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic              misaligned,
  output logic              illegal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] c_f3_sb = 3'd0;
  localparam logic [2:0] c_f3_sh = 3'd1;
  localparam logic [2:0] c_f3_sw = 3'd2;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wbuf;
  logic              r_misaligned;
  logic              r_illegal;

  logic              w_req_illegal;
  logic              w_req_misaligned;
  logic              w_accept;
  logic [31:0]       w_merged;

  assign w_req_illegal    = (funct3 != c_f3_sb) && (funct3 != c_f3_sh) && (funct3 != c_f3_sw);
  assign w_req_misaligned = ((funct3 == c_f3_sh) && addr[0]) ||
                            ((funct3 == c_f3_sw) && (addr[1:0] != 2'b00));
  assign w_accept         = (r_state == S_IDLE) && req_valid;

  // r_wbuf holds the raw store data until the read returns, then the merged word.
  always_comb begin
    w_merged = mem_rdata;
    case (r_funct3)
      c_f3_sb: w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wbuf[7:0];
      c_f3_sh: w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wbuf[15:0];
      default: w_merged = r_wbuf;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_funct3     <= 3'd0;
      r_addr       <= '0;
      r_wbuf       <= 32'd0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_funct3     <= funct3;
        r_addr       <= addr;
        r_wbuf       <= wdata;
        r_illegal    <= w_req_illegal;
        r_misaligned <= w_req_misaligned && !w_req_illegal;
      end else if ((r_state == S_READ) && mem_rvalid) begin
        r_wbuf <= w_merged;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    misaligned  = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_illegal || w_req_misaligned)
            w_state_nxt = S_RESP;
          else if ((funct3 == c_f3_sw) && SW_BYPASS)
            w_state_nxt = S_WRITE;
          else
            w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_re = 1'b1;
        if (mem_rvalid) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (mem_wack) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        done        = 1'b1;
        misaligned  = r_misaligned;
        illegal     = r_illegal;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = r_wbuf;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
`default_nettype none
// Directed stores against a latency-configurable memory model; a scoreboard
// holds the expected write and response of each request until done.
module tb_store_rmw_unit;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        funct3 = 3'd0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = 32'd0;
  logic              done, misaligned, illegal;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_rvalid, mem_we, mem_wack;
  logic [31:0]       mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(ADDR_W), .SW_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .addr(addr), .wdata(wdata), .done(done),
    .misaligned(misaligned), .illegal(illegal), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wack(mem_wack)
  );

  // memory model: response after a programmable number of wait cycles
  logic [31:0] rd_word = 32'd0;
  int          rd_delay = 0, wr_delay = 0;
  logic        wr_hold = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0;

  assign mem_rdata  = rd_word;
  assign mem_rvalid = mem_re && (rd_cnt >= rd_delay);
  assign mem_wack   = mem_we && !wr_hold && (wr_cnt >= wr_delay);

  always @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      rd_cnt <= (mem_re && !mem_rvalid) ? rd_cnt + 1 : 0;
      wr_cnt <= (mem_we && !mem_wack) ? wr_cnt + 1 : 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        do_write;
    logic [31:0] waddr;
    logic [31:0] wword;
    logic        mis;
    logic        ill;
    int          re_cyc;
    int          we_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   acc_cyc = 0, last_acc_cyc = 0, last_done_cyc = 0;
  int   re_cnt = 0, we_cnt = 0, done_cnt = 0;
  logic in_flight = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // monitor: samples on the falling edge, compares against the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (mem_re || mem_we) check("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
      if (in_flight) check("ready_low_busy", {31'd0, req_ready}, 32'd0);
      if (mem_re) begin
        re_cnt++;
        if (sb.size() > 0) check("re_addr", mem_addr, sb[0].waddr);
      end
      if (mem_we) begin
        we_cnt++;
        if (mem_wack && sb.size() > 0) begin
          check("we_addr", mem_addr, sb[0].waddr);
          check("we_data", mem_wdata, sb[0].wword);
        end
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          check("illegal", {31'd0, illegal}, {31'd0, e.ill});
          check("re_cycles", re_cnt, e.re_cyc);
          check("we_cycles", we_cnt, e.we_cyc);
          check("latency", cyc - acc_cyc, 1 + e.re_cyc + e.we_cyc);
        end
        in_flight     = 1'b0;
        last_done_cyc = cyc;
      end
      if (req_valid && req_ready) begin
        acc_cyc      = cyc;
        last_acc_cyc = cyc;
        re_cnt       = 0;
        we_cnt       = 0;
        in_flight    = 1'b1;
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdw, input int rdel, input int wdel, input logic keep);
    exp_t        e;
    logic [31:0] mask, shifted;
    logic        ok;
    int          n;
    rd_word  = rdw;
    rd_delay = rdel;
    wr_delay = wdel;
    e.ill    = (f3 > 3'd2);
    e.mis    = !e.ill && (((f3 == 3'd1) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00)));
    e.do_write = !(e.ill || e.mis);
    e.waddr  = a & 32'hFFFF_FFFC;
    case (f3)
      3'd0:    begin mask = 32'h0000_00FF << (8 * a[1:0]); shifted = {24'd0, wd[7:0]} << (8 * a[1:0]); end
      3'd1:    begin mask = 32'h0000_FFFF << (16 * a[1]);  shifted = {16'd0, wd[15:0]} << (16 * a[1]); end
      default: begin mask = 32'hFFFF_FFFF; shifted = wd; end
    endcase
    e.wword  = (rdw & ~mask) | (shifted & mask);
    e.re_cyc = (e.do_write && f3 != 3'd2) ? rdel + 1 : 0;
    e.we_cyc = e.do_write ? wdel + 1 : 0;
    sb.push_back(e);
    funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin @(posedge clk); n++; end
    check("done_timeout", {31'd0, done_cnt >= target}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, saved;
    @(posedge clk); @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {30'd0, misaligned, illegal}, 32'd0);
    check("rst_mem_ctl", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    issue(3'd0, 32'h102, 32'h0000_00AB, 32'h1122_3344, 0, 0, 1'b0); wait_done(1);
    issue(3'd1, 32'h206, 32'h0000_BEEF, 32'hCAFE_D00D, 3, 0, 1'b0); wait_done(2);
    issue(3'd2, 32'h040, 32'hDEAD_BEEF, 32'h5555_5555, 0, 2, 1'b0); wait_done(3);
    issue(3'd1, 32'h003, 32'h0000_1234, 32'h0, 0, 0, 1'b0);         wait_done(4);
    issue(3'd2, 32'h042, 32'h1234_5678, 32'h0, 0, 0, 1'b0);         wait_done(5);
    issue(3'd3, 32'h010, 32'h1234_5678, 32'h0, 0, 0, 1'b0);         wait_done(6);
    issue(3'd7, 32'h001, 32'h1234_5678, 32'h0, 0, 0, 1'b0);         wait_done(7);
    issue(3'd0, 32'h107, 32'h0000_0055, 32'hA1B2_C3D4, 1, 1, 1'b0); wait_done(8);
    issue(3'd0, 32'h104, 32'h0000_0066, 32'hA1B2_C3D4, 0, 0, 1'b0); wait_done(9);
    issue(3'd1, 32'h108, 32'h0000_7788, 32'h0102_0304, 0, 1, 1'b0); wait_done(10);

    // reset abandons a write stalled on mem_wack
    wr_hold = 1'b1;
    issue(3'd0, 32'h080, 32'h0000_00CC, 32'h0, 0, 0, 1'b0);
    n = 0;
    while (!mem_we && n < 20) begin @(negedge clk); n++; end
    check("stall_we_seen", {31'd0, mem_we}, 32'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    sb.delete();
    in_flight = 1'b0;
    saved = done_cnt;
    @(posedge clk); #1 rst = 1'b0; wr_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, saved);
    check("rst_no_we", {30'd0, mem_re, mem_we}, 32'd0);
    issue(3'd0, 32'h081, 32'h0000_00EE, 32'h8899_AABB, 0, 0, 1'b0); wait_done(saved + 1);

    // back-to-back with req_valid held high
    issue(3'd0, 32'h300, 32'h0000_0011, 32'hFFFF_FFFF, 0, 0, 1'b1);
    issue(3'd0, 32'h302, 32'h0000_0022, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("b2b_spacing", last_acc_cyc - last_done_cyc, 32'd1);
    wait_done(saved + 3);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load part-select/extend logic.
- Takes a core store request (SB/SH/SW encoded in funct3) and writes it to a word-only data memory.
- SB/SH use a read-modify-write sequence: read the word, merge the byte or halfword lane, write back.
- Sits between the core MEM stage and the data memory port. Reports completion, misalignment and illegal-funct3 errors.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_addr.
- SW_BYPASS, 1, 1 = aligned SW skips the read phase and writes directly; 0 = SW also performs a read first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- funct3  input  3  store size: 0 = SB, 1 = SH, 2 = SW; any other value is illegal.
- addr  input  ADDR_W  byte address of the store.
- wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
- done  output  1  one-cycle pulse when a request finishes (success or error).
- misaligned  output  1  valid with done: SH with addr[0]=1, or SW with addr[1:0]!=0.
- illegal  output  1  valid with done: funct3 is not 0, 1 or 2.
- mem_addr  output  ADDR_W  word-aligned address: latched addr with bits [1:0] forced to 0.
- mem_re  output  1  memory read request.
- mem_rdata  input  32  memory read data.
- mem_rvalid  input  1  mem_rdata is valid.
- mem_we  output  1  memory write request (full word).
- mem_wdata  output  32  merged word to write.
- mem_wack  input  1  memory accepted the write.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE immediately.
  - req_ready=1; done, misaligned, illegal, mem_re, mem_we = 0; mem_addr and mem_wdata = 0.
  - Reset mid-operation abandons the transfer. Nothing further is driven to memory.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch funct3, addr and wdata, then branch on the request type:
    - Illegal funct3 -> RESP with illegal=1. Illegal takes priority over misaligned.
    - Misaligned -> RESP with misaligned=1.
    - SW with SW_BYPASS=1 -> WRITE, with mem_wdata = wdata.
    - Otherwise -> READ.
- READ:
  - mem_re=1 and held until mem_rvalid=1.
  - In the cycle mem_rvalid=1, merge mem_rdata into the write buffer and go to WRITE.
  - The memory may hold mem_rvalid low for any number of cycles; there is no timeout.
- Merge rules, k = latched addr[1:0]:
  - SB: bits [8k+7:8k] = wdata[7:0]; all other bytes come from mem_rdata.
  - SH: lane = addr[1]; bits [16*lane+15:16*lane] = wdata[15:0]; the other half comes from mem_rdata.
  - SW (SW_BYPASS=0): mem_wdata = wdata; mem_rdata is discarded.
- WRITE:
  - mem_we=1, with mem_addr and mem_wdata held stable, until mem_wack=1.
  - Then go to RESP.
- RESP:
  - done=1 for exactly one cycle; misaligned and illegal are valid in the same cycle.
  - Next state is IDLE. A new request can be accepted in the following cycle, so minimum spacing between requests is 1 cycle.
- Error and ignored inputs:
  - Error paths issue no mem_re and no mem_we.
  - mem_rvalid outside READ and mem_wack outside WRITE are ignored.
  - mem_re and mem_we are never high in the same cycle.
- Latency with zero-wait memory:
  - SB/SH: 4 cycles, accept to done (IDLE, READ, WRITE, RESP).
  - SW bypass: 3 cycles.
  - Error: 2 cycles.
- req_valid while req_ready=0 is not accepted. The requester holds the request until it sees req_ready=1.

Test Plan:
- SB: addr=0x102, wdata=0xAB, mem_rdata=0x11223344, zero-wait memory -> mem_re with mem_addr=0x100; then mem_we with mem_wdata=0x11AB3344; done at accept+3; no error flags.
- SH: addr=0x206, wdata=0xBEEF, mem_rdata=0xCAFED00D, mem_rvalid delayed 3 cycles -> mem_re held 4 cycles; mem_wdata=0xBEEFD00D, mem_addr=0x204.
- SW: addr=0x40, wdata=0xDEADBEEF, SW_BYPASS=1, mem_wack delayed 2 cycles -> no mem_re; mem_we held 3 cycles with 0xDEADBEEF; single done pulse.
- Errors:
  - SH at addr=0x3, and SW at addr=0x42 -> done with misaligned=1 at accept+1; mem_re and mem_we never asserted.
  - funct3=3 -> done with illegal=1.
- rst pulsed while in WRITE with mem_wack held low -> mem_we drops immediately; req_ready=1; no done pulse. A following SB completes normally.
- Back-to-back SB requests with req_valid held high -> second request accepted the cycle after done; req_ready low throughout the first transfer.
